// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller with a gated 1 Hz tick and a BCD mm:ss counter.
// A lap latch can freeze the displayed time while the live count keeps running.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk_50mHz,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       lap_hold,
   output logic       tick_1hz,
   output logic       wrap
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_e;

   typedef struct packed {
      logic [3:0] m10;
      logic [3:0] m1;
      logic [3:0] s10;
      logic [3:0] s1;
   } mmss_t;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   mmss_t         live_q, live_d;
   mmss_t         lap_q, lap_d;
   logic          lap_hold_q, lap_hold_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

   // Ripple-carry BCD increment; every digit rolls over at its own limit.
   function automatic mmss_t bcd_inc(input mmss_t v);
      mmss_t r;
      r = v;
      if (v.s1 != 4'd9) r.s1 = v.s1 + 4'd1;
      else begin
         r.s1 = 4'd0;
         if (v.s10 != 4'd5) r.s10 = v.s10 + 4'd1;
         else begin
            r.s10 = 4'd0;
            if (v.m1 != 4'd9) r.m1 = v.m1 + 4'd1;
            else begin
               r.m1  = 4'd0;
               r.m10 = (v.m10 != 4'd5) ? v.m10 + 4'd1 : 4'd0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every _d gets a hold/default value first so no path infers a latch.
      state_d    = state_q;
      pre_d      = pre_q;
      live_d     = live_q;
      lap_d      = lap_q;
      lap_hold_d = lap_hold_q;
      tick_d     = 1'b0;
      wrap_d     = 1'b0;

      if (btn_clear) begin
         state_d    = ST_IDLE;
         pre_d      = '0;
         live_d     = '0;
         lap_hold_d = 1'b0;
      end else begin
         // The prescaler advances on every RUN edge, including a pausing one.
         if (state_q == ST_RUN) begin
            if (pre_q == PRE_LAST) begin
               pre_d  = '0;
               live_d = bcd_inc(live_q);
               tick_d = 1'b1;
               wrap_d = (live_q == 16'h5959);
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end

         if (btn_lap) begin
            if (lap_hold_q && state_q != ST_IDLE) begin
               lap_hold_d = 1'b0;
            end else if (!lap_hold_q && state_q == ST_RUN) begin
               lap_d      = live_q;
               lap_hold_d = 1'b1;
            end
         end

         if (btn_start) begin
            case (state_q)
               ST_IDLE:  state_d = ST_RUN;
               ST_RUN:   state_d = ST_PAUSE;
               ST_PAUSE: state_d = ST_RUN;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_50mHz) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         live_q     <= '0;
         lap_q      <= '0;
         lap_hold_q <= 1'b0;
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         live_q     <= live_d;
         lap_q      <= lap_d;
         lap_hold_q <= lap_hold_d;
         tick_q     <= tick_d;
         wrap_q     <= wrap_d;
      end
   end

   mmss_t disp;
   assign disp     = lap_hold_q ? lap_q : live_q;
   assign sec_ones = disp.s1;
   assign sec_tens = disp.s10;
   assign min_ones = disp.m1;
   assign min_tens = disp.m10;
   assign running  = (state_q == ST_RUN);
   assign lap_hold = lap_hold_q;
   assign tick_1hz = tick_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// all checked against an integer-seconds reference model.
module tb_stopwatch_ctrl;

   localparam int DIV = 4;

   logic       clk_50mHz = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, lap_hold, tick_1hz, wrap;

   int total = 0;
   int bad   = 0;

   // Reference model: whole seconds since 00:00, a plain cycle counter and a mode number.
   int m_mode   = 0;   // 0 stopped-and-zeroed, 1 counting, 2 paused
   int m_frac   = 0;
   int m_secs   = 0;
   int m_frozen = 0;
   bit m_lap    = 1'b0;
   bit m_tick   = 1'b0;
   bit m_wrap   = 1'b0;

   stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
      .clk_50mHz (clk_50mHz),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .btn_lap   (btn_lap),
      .sec_ones  (sec_ones),
      .sec_tens  (sec_tens),
      .min_ones  (min_ones),
      .min_tens  (min_tens),
      .running   (running),
      .lap_hold  (lap_hold),
      .tick_1hz  (tick_1hz),
      .wrap      (wrap)
   );

   always #5 clk_50mHz = ~clk_50mHz;

   logic [19:0] dut_v;
   logic [15:0] dut_disp;
   assign dut_v    = {min_tens, min_ones, sec_tens, sec_ones, running, lap_hold, tick_1hz, wrap};
   assign dut_disp = dut_v[19:4];

   function automatic logic [19:0] exp_vec();
      int shown, mm, ss;
      shown = m_lap ? m_frozen : m_secs;
      mm = shown / 60;
      ss = shown % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              (m_mode == 1), m_lap, m_tick, m_wrap};
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit c, input bit l);
      int  old_secs, old_mode;
      bit  old_lap;
      if (r) begin
         m_mode = 0; m_frac = 0; m_secs = 0; m_frozen = 0;
         m_lap = 0; m_tick = 0; m_wrap = 0;
      end else if (c) begin
         m_mode = 0; m_frac = 0; m_secs = 0;
         m_lap = 0; m_tick = 0; m_wrap = 0;
      end else begin
         old_secs = m_secs;
         old_mode = m_mode;
         old_lap  = m_lap;
         m_tick = 0;
         m_wrap = 0;
         if (old_mode == 1) begin
            m_frac = m_frac + 1;
            if (m_frac == DIV) begin
               m_frac = 0;
               m_secs = (old_secs + 1) % 3600;
               m_tick = 1;
               m_wrap = (m_secs == 0);
            end
         end
         if (l) begin
            if (old_lap && old_mode != 0) m_lap = 0;
            else if (!old_lap && old_mode == 1) begin
               m_frozen = old_secs;
               m_lap    = 1;
            end
         end
         if (s) m_mode = (old_mode == 1) ? 2 : 1;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit c, input bit l);
      rst = r; btn_start = s; btn_clear = c; btn_lap = l;
      @(posedge clk_50mHz);
      model_edge(r, s, c, l);
      #1;
      rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0);
      step(1, 1, 0, 1);
      total++;
      if (dut_v !== 20'h0) begin
         bad++; $display("FAIL reset_outputs: got %h want %h", dut_v, 20'h0);
      end
   endtask

   task automatic test_run();
      int ticks = 0;
      int last = -1;
      step(0, 1, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL run_cycle%0d: got %h want %h", i, dut_v, exp_vec());
         end
         if (tick_1hz === 1'b1) begin
            if (last >= 0) begin
               total++;
               if (i - last !== DIV) begin
                  bad++; $display("FAIL run_tick_spacing: got %0d want %0d", i - last, DIV);
               end
            end
            last = i;
            ticks++;
         end
      end
      total++;
      if (ticks !== 10) begin bad++; $display("FAIL run_tick_count: got %0d want 10", ticks); end
      total++;
      if (dut_disp !== 16'h0010) begin bad++; $display("FAIL run_display: got %h want 0010", dut_disp); end
      total++;
      if (running !== 1'b1) begin bad++; $display("FAIL run_running: got %b want 1", running); end
   endtask

   task automatic test_wrap();
      int wraps = 0;
      int i = 0;
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      while (i < 20000 && !(m_secs == 3598 && m_tick)) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL wrap_preload%0d: got %h want %h", i, dut_v, exp_vec());
         end
         i++;
      end
      total++;
      if (!(m_secs == 3598 && m_tick)) begin bad++; $display("FAIL wrap_preload_timeout: got %0d want 3598", m_secs); end
      for (int k = 0; k < 9; k++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL wrap_cycle%0d: got %h want %h", k, dut_v, exp_vec());
         end
         if (wrap === 1'b1) wraps++;
         if (k == 3) begin
            total++;
            if (dut_disp !== 16'h5959 || wrap !== 1'b0) begin
               bad++; $display("FAIL wrap_5959: got %h/%b want 5959/0", dut_disp, wrap);
            end
         end
         if (k == 7) begin
            total++;
            if (dut_disp !== 16'h0000 || wrap !== 1'b1 || tick_1hz !== 1'b1) begin
               bad++; $display("FAIL wrap_0000: got %h/%b/%b want 0000/1/1", dut_disp, wrap, tick_1hz);
            end
         end
      end
      total++;
      if (wraps !== 1) begin bad++; $display("FAIL wrap_pulse_width: got %0d want 1", wraps); end
   endtask

   task automatic test_pause();
      int ticks = 0;
      int first = -1;
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      total++;
      if (dut_v !== exp_vec() || running !== 1'b0 || m_frac !== 2) begin
         bad++; $display("FAIL pause_enter: got %h want %h", dut_v, exp_vec());
      end
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL pause_hold%0d: got %h want %h", i, dut_v, exp_vec());
         end
         if (tick_1hz === 1'b1) ticks++;
      end
      total++;
      if (ticks !== 0) begin bad++; $display("FAIL pause_no_tick: got %0d want 0", ticks); end
      step(0, 1, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL pause_resume%0d: got %h want %h", i, dut_v, exp_vec());
         end
         if (tick_1hz === 1'b1 && first < 0) first = i;
      end
      total++;
      if (first !== 2) begin bad++; $display("FAIL pause_resume_latency: got %0d want 2", first); end
   endtask

   task automatic test_lap();
      int i = 0;
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      while (i < 200 && !(m_secs == 5 && m_tick)) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL lap_reach%0d: got %h want %h", i, dut_v, exp_vec());
         end
         i++;
      end
      step(0, 0, 0, 1);
      total++;
      if (dut_disp !== 16'h0005 || lap_hold !== 1'b1) begin
         bad++; $display("FAIL lap_latch: got %h/%b want 0005/1", dut_disp, lap_hold);
      end
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL lap_frozen%0d: got %h want %h", k, dut_v, exp_vec());
         end
      end
      total++;
      if (dut_disp !== 16'h0005) begin bad++; $display("FAIL lap_still_05: got %h want 0005", dut_disp); end
      step(0, 0, 0, 1);
      total++;
      if (dut_disp !== 16'h0007 || lap_hold !== 1'b0) begin
         bad++; $display("FAIL lap_release: got %h/%b want 0007/0", dut_disp, lap_hold);
      end
   endtask

   task automatic test_clear_start();
      int i = 0;
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      while (i < 200 && !(m_secs == 3 && m_frac == DIV - 1)) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL clr_reach%0d: got %h want %h", i, dut_v, exp_vec());
         end
         i++;
      end
      step(0, 1, 1, 0);
      total++;
      if (dut_v !== 20'h0) begin bad++; $display("FAIL clr_priority: got %h want 00000", dut_v); end
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL clr_idle%0d: got %h want %h", k, dut_v, exp_vec());
         end
      end
   endtask

   task automatic test_start_terminal();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      for (int k = 0; k < DIV - 1; k++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      total++;
      if (tick_1hz !== 1'b1 || running !== 1'b0 || dut_disp !== 16'h0001) begin
         bad++; $display("FAIL term_pause: got %h/%b/%b want 0001/1/0", dut_disp, tick_1hz, running);
      end
      for (int k = 0; k < 10; k++) begin
         step(0, (k == 5), 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL term_after%0d: got %h want %h", k, dut_v, exp_vec());
         end
      end
   endtask

   task automatic test_rst_mid();
      int i = 0;
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      while (i < 5000 && m_secs != 754) begin
         step(0, 0, 0, (m_secs == 750 && m_tick));
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL rst_reach%0d: got %h want %h", i, dut_v, exp_vec());
         end
         i++;
      end
      total++;
      if (lap_hold !== 1'b1 || m_secs !== 754) begin
         bad++; $display("FAIL rst_setup: got lap=%b secs=%0d want 1/754", lap_hold, m_secs);
      end
      step(1, 1, 0, 1);
      total++;
      if (dut_v !== 20'h0) begin bad++; $display("FAIL rst_mid: got %h want 00000", dut_v); end
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 0, 0);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL rst_idle%0d: got %h want %h", k, dut_v, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit r, s, c, l;
      step(0, 0, 1, 0);
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 999) == 0);
         s = ($urandom_range(0, 29) == 0);
         c = ($urandom_range(0, 299) == 0);
         l = ($urandom_range(0, 19) == 0);
         step(r, s, c, l);
         total++;
         if (dut_v !== exp_vec()) begin
            bad++; $display("FAIL random%0d: got %h want %h", i, dut_v, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_wrap();
      test_pause();
      test_lap();
      test_clear_start();
      test_start_terminal();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
